// File: rtl/vec_mem_responder.sv
// Memory-side responder for the vector ASIP memory stage: scalar/vector burst
// reads and writes against an internal byte RAM with a fixed read latency.
module vec_mem_responder #(
  parameter int DEPTH = 1024,
  parameter int LANES = 20,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [4:0]  req_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_BEAT = 3'd2,
    WR_BEAT = 3'd3,
    WR_ACK  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic           en_q;
  logic [AW-1:0]  addr_q;
  logic [4:0]     len_q;
  logic [4:0]     idx_q;
  logic           err_q;
  logic [2:0]     cnt_q;
  logic [7:0]     data_q;
  logic [7:0]     mem [DEPTH];

  logic           accept;
  logic           req_err;
  logic [32:0]    req_end;
  logic           last_beat;
  logic           rsp_hs;
  logic           wr_hs;
  logic [4:0]     rd_idx;
  logic [AW-1:0]  rd_addr;
  logic [AW-1:0]  wr_addr;

  // Every channel transfers on a rising edge where valid and ready are both
  // high; the valid side holds its payload stable until that edge.
  assign accept  = req_valid & req_ready;
  assign rsp_hs  = rsp_valid & rsp_ready;
  assign wr_hs   = wr_valid & wr_ready;

  assign req_end = {1'b0, req_addr} + {28'd0, req_len};
  assign req_err = (req_len == 5'd0) || ({27'd0, req_len} > 32'(LANES)) ||
                   (req_end > 33'(DEPTH));

  // A zero-length (always erroneous) read still produces one terminating beat.
  assign last_beat = (idx_q == len_q - 5'd1) || (len_q == 5'd0);

  assign rd_idx  = (state_q == RD_BEAT) ? idx_q + 5'd1 : idx_q;
  assign rd_addr = addr_q + AW'(rd_idx);
  assign wr_addr = addr_q + AW'(idx_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!req_write)                        state_d = RD_WAIT;
          else if (req_err && req_len == 5'd0)   state_d = WR_ACK;
          else                                   state_d = WR_BEAT;
        end
      end
      RD_WAIT: if (cnt_q == 3'd0)                state_d = RD_BEAT;
      RD_BEAT: if (rsp_hs && last_beat)          state_d = IDLE;
      WR_BEAT: if (wr_hs && idx_q == len_q - 5'd1) state_d = WR_ACK;
      WR_ACK:  if (rsp_hs)                       state_d = IDLE;
      default:                                   state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = 8'd0;
    rsp_last  = 1'b0;
    rsp_err   = 1'b0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      IDLE:    req_ready = en_q;
      WR_BEAT: wr_ready  = 1'b1;
      RD_BEAT: begin
        rsp_valid = 1'b1;
        rsp_data  = data_q;
        rsp_last  = last_beat;
        rsp_err   = err_q;
      end
      WR_ACK: begin
        rsp_valid = 1'b1;
        rsp_last  = 1'b1;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

  // en_q keeps req_ready low until the first clock after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      len_q  <= 5'd0;
      idx_q  <= 5'd0;
      err_q  <= 1'b0;
      cnt_q  <= 3'd0;
      data_q <= 8'd0;
    end else begin
      en_q <= 1'b1;
      if (accept) begin
        addr_q <= req_addr[AW-1:0];
        len_q  <= req_len;
        err_q  <= req_err;
        idx_q  <= 5'd0;
        cnt_q  <= 3'(LAT - 1);
      end else begin
        case (state_q)
          RD_WAIT: begin
            if (cnt_q != 3'd0) cnt_q  <= cnt_q - 3'd1;
            else               data_q <= err_q ? 8'd0 : mem[rd_addr];
          end
          RD_BEAT: begin
            if (rsp_hs && !last_beat) begin
              idx_q  <= idx_q + 5'd1;
              data_q <= err_q ? 8'd0 : mem[rd_addr];
            end
          end
          WR_BEAT: if (wr_hs) idx_q <= idx_q + 5'd1;
          default: ;
        endcase
      end
    end
  end

  // RAM contents survive reset; erroneous bursts are consumed without writing.
  always_ff @(posedge clk) begin
    if (state_q == WR_BEAT && wr_valid && !err_q) mem[wr_addr] <= wr_data;
  end

endmodule

// File: doc/vec_mem_responder.md
Name: vec_mem_responder

Overview:
- Memory-side responder for the vector ASIP's memory stage.
- Accepts single-byte (scalar) and multi-byte burst (vector, up to LANES bytes) read and write requests over a valid/ready handshake.
- Backs requests with an internal byte-addressed RAM of DEPTH bytes, with a configurable read latency.
- Returns read data beat-by-beat; issues one acknowledge beat per write burst.

Parameters:
- DEPTH, 1024: RAM size in bytes; legal addresses are 0..DEPTH-1.
- LANES, 20: maximum burst length in bytes (one vector).
- LAT, 2: cycles from request acceptance to the first read beat; legal range 1..4.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  32  start byte address.
- req_len  in  5  burst length in bytes; 1 = scalar, 2..LANES = vector.
- wr_valid  in  1  write data beat present.
- wr_ready  out  1  responder accepts the write beat.
- wr_data  in  8  write data byte.
- rsp_valid  out  1  response beat present.
- rsp_ready  in  1  initiator accepts the response beat.
- rsp_data  out  8  read byte; 0 for write acks and for error beats.
- rsp_last  out  1  final beat of the response.
- rsp_err  out  1  request was illegal.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: async assert forces state IDLE immediately.
  - req_ready=0 while rst is high, and becomes 1 on the first clock after release.
  - wr_ready=0, rsp_valid=0, rsp_data=0, rsp_last=0, rsp_err=0, busy=0.
  - RAM contents are not cleared by reset.
- Request legality: error when any of the following holds:
  - req_len==0;
  - req_len>LANES;
  - req_addr+req_len>DEPTH, evaluated at 33-bit width so there is no wrap.
  - Example: addr 0xFFFF is an error for any length.
- Acceptance: a request is accepted on a cycle where req_valid&req_ready.
  - addr, len, write and err are captured at acceptance.
  - req_ready=1 only in IDLE.
- FSM states: IDLE, RD_WAIT, RD_BEAT, WR_BEAT, WR_ACK.
- IDLE:
  - on accepted read -> RD_WAIT; latency counter loaded with LAT-1.
  - on accepted write -> WR_BEAT, except err with len==0 -> WR_ACK.
- RD_WAIT: counter decrements; at 0 -> RD_BEAT.
  - The first rsp_valid appears exactly LAT cycles after the acceptance edge.
- RD_BEAT:
  - rsp_valid=1; rsp_data=RAM[addr+i] (registered); rsp_last=1 when i==len-1.
  - rsp_err=err for every beat; if err, data=0 and RAM is not read.
  - An err read with len==0 emits a single beat with last=1.
  - Beat advances only on rsp_valid&rsp_ready; data/last/err are held stable while stalled.
  - After the last beat handshake -> IDLE.
  - Back-to-back beats at one per cycle when rsp_ready is held high.
- WR_BEAT:
  - wr_ready=1; each wr_valid&wr_ready beat writes RAM[addr+i]=wr_data and increments i.
  - If err, beats are consumed but discarded.
  - After beat len-1 -> WR_ACK.
  - wr_valid low inserts bubbles with no effect.
- WR_ACK: rsp_valid=1, rsp_last=1, rsp_data=0, rsp_err=err; on rsp_ready -> IDLE.
- Write-then-read: a read accepted the cycle after the WR_ACK handshake returns the new data.
- Reset mid-burst: returns to IDLE at once.
  - Bytes already written stay committed.
  - Any pending response is dropped, and no ack is produced.
- Beat index i: 5-bit counter, cleared on acceptance.
- Address arithmetic: addr+i; no wrap is possible for a legal request.

Test Plan:
- Reset with rst=1 for 10 ps then release -> all outputs 0 during reset; req_ready=1 on the first clock after release; busy=0.
- Vector write addr=0, len=20, bytes 50..69, rsp_ready=1 -> 20 wr handshakes, then one ack with last=1, err=0; vector read addr=0, len=20 -> first beat LAT cycles after acceptance, data 50..69, last only on the 20th beat.
- Scalar write addr=20, data=25, then scalar read addr=20 -> single beat data=25, last=1; a vector read at addr=20 returns 25 followed by the prior contents.
- Read addr=0xFFFF, len=1 -> one beat err=1, data=0, last=1; write addr=1010, len=20 -> 20 beats consumed, ack err=1; RAM[1010..1023] unchanged.
- Read len=20 with rsp_ready toggling 1,0,0,1… -> outputs held while stalled; all 20 bytes delivered in order with none duplicated; len=0 -> single err beat.
- Assert rst after 8 write beats of a 20-byte burst -> IDLE immediately with no ack; a subsequent read shows the 8 new bytes and the other 12 bytes unchanged.
